// File: rtl/pattern_detector_pkg.sv
// -----------------------------------------------------------------------------
// pattern_detector_pkg
// Shared types for the serial pattern detector.
//   state_t  : FSM state encoding, also exported on CurState
//   id_width : width of the MatchId port for a given pattern count
// -----------------------------------------------------------------------------
package pattern_detector_pkg;

    // 2'd3 is intentionally not a member; the FSM recovers from it to ST_FILL.
    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,  // fewer than LEN valid history bits
        ST_SEARCH = 2'd1,  // history full, last bit did not complete a match
        ST_MATCH  = 2'd2   // last consumed bit completed a match
    } state_t;

    // A single pattern still needs a one-bit index port.
    function automatic int id_width(input int npat);
        return (npat > 1) ? $clog2(npat) : 1;
    endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   Clock  : rising-edge clock
//   Reset  : synchronous active-high reset (count -> 0)
//   clr    : synchronous clear, has priority over inc
//   inc    : increment by one, holds at all-ones
//   count  : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge Clock) begin
        if (Reset || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CW{1'b1}})) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pattern_detector.sv
// -----------------------------------------------------------------------------
// pattern_detector
// Serial multi-pattern detector. Bits arrive MSB-first on w when Valid is high
// and are shifted into a LEN-bit history. Once LEN bits have been collected,
// the history is compared against NPAT programmable patterns; a hit produces a
// one-cycle Moore pulse on z (latency 1), records the lowest matching pattern
// index and bumps a saturating hit counter.
//   Clock    : rising-edge clock
//   Reset    : synchronous active-high reset, highest priority
//   Load     : capture PatIn, clear history/fill/Hits, force FILL (beats Valid)
//   PatIn    : pattern i at [i*LEN +: LEN], MSB received first
//   Overlap  : 1 = keep history after a match, 0 = restart fill after a match
//   Valid    : qualifies w
//   w        : serial data bit
//   z        : high while in MATCH
//   MatchId  : index of the last matched pattern
//   Hits     : saturating match count
//   CurState : encoded FSM state
// -----------------------------------------------------------------------------
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int LEN  = 4,
    parameter int NPAT = 2,
    parameter int CW   = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Load,
    input  logic [NPAT*LEN-1:0]       PatIn,
    input  logic                      Overlap,
    input  logic                      Valid,
    input  logic                      w,
    output logic                      z,
    output logic [id_width(NPAT)-1:0] MatchId,
    output logic [CW-1:0]             Hits,
    output logic [1:0]                CurState
);

    localparam int              MW   = id_width(NPAT);
    localparam int              FW   = $clog2(LEN + 1);
    localparam logic [FW-1:0]   FULL = FW'(LEN);

    // Registered state
    logic [LEN-1:0] pat_reg [NPAT];
    logic [LEN-1:0] hist_reg,     hist_next;
    logic [FW-1:0]  fill_reg,     fill_next;
    state_t         state_reg,    state_next;
    logic [MW-1:0]  match_id_reg, match_id_next;

    // Combinational match path
    logic [LEN-1:0]  hist_shift;
    logic [FW-1:0]   fill_inc;
    logic [NPAT-1:0] hit;
    logic [MW-1:0]   win_id;
    logic            consume;
    logic            match;

    assign consume    = Valid && !Load;
    assign hist_shift = {hist_reg[LEN-2:0], w};
    assign fill_inc   = (fill_reg == FULL) ? FULL : fill_reg + FW'(1);

    // Compare the post-shift history with every pattern in parallel.
    generate
        for (genvar gi = 0; gi < NPAT; gi++) begin : g_cmp
            assign hit[gi] = (hist_shift == pat_reg[gi]);
        end
    endgenerate

    // Lowest index wins: scan downward so the last assignment is the lowest hit.
    always_comb begin
        win_id = '0;
        for (int i = NPAT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_id = MW'(i);
            end
        end
    end

    assign match = consume && (fill_inc == FULL) && (|hit);

    // Next-state and datapath update
    always_comb begin
        hist_next     = hist_reg;
        fill_next     = fill_reg;
        state_next    = state_reg;
        match_id_next = match_id_reg;

        if (Load) begin
            hist_next  = '0;
            fill_next  = '0;
            state_next = ST_FILL;
        end else if (Valid) begin
            hist_next = hist_shift;
            if (match) begin
                // Non-overlapping mode restarts collection so no bit is reused;
                // the stale history is harmless because fill must refill first.
                fill_next     = Overlap ? fill_inc : '0;
                state_next    = ST_MATCH;
                match_id_next = win_id;
            end else begin
                fill_next  = fill_inc;
                state_next = (fill_inc < FULL) ? ST_FILL : ST_SEARCH;
            end
        end else begin
            // Idle cycle: only leave MATCH so z stays a single-cycle pulse.
            case (state_reg)
                ST_FILL:   state_next = ST_FILL;
                ST_SEARCH: state_next = ST_SEARCH;
                ST_MATCH:  state_next = Overlap ? ST_SEARCH : ST_FILL;
                default:   state_next = ST_FILL;
            endcase
        end

        // The unused encoding always falls back to FILL.
        if ((state_reg != ST_FILL) && (state_reg != ST_SEARCH) &&
            (state_reg != ST_MATCH) && !match) begin
            state_next = ST_FILL;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hist_reg     <= '0;
            fill_reg     <= '0;
            state_reg    <= ST_FILL;
            match_id_reg <= '0;
            for (int i = 0; i < NPAT; i++) begin
                pat_reg[i] <= '0;
            end
        end else begin
            hist_reg     <= hist_next;
            fill_reg     <= fill_next;
            state_reg    <= state_next;
            match_id_reg <= match_id_next;
            if (Load) begin
                for (int i = 0; i < NPAT; i++) begin
                    pat_reg[i] <= PatIn[i*LEN +: LEN];
                end
            end
        end
    end

    sat_counter #(
        .CW (CW)
    ) u_hits (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (match),
        .clr   (Load),
        .count (Hits)
    );

    assign z        = (state_reg == ST_MATCH);
    assign MatchId  = match_id_reg;
    assign CurState = state_reg;

endmodule

// File: tb/tb_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_pattern_detector
// Drives two detector instances (CW=8 and CW=2) with the same stimulus and
// compares every output after each clock edge against a queue-based model of
// the detection rules.
// -----------------------------------------------------------------------------
module tb_pattern_detector;

    localparam int LEN  = 4;
    localparam int NPAT = 2;
    localparam int PW   = NPAT * LEN;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Load = 1'b0;
    logic [PW-1:0] PatIn = '0;
    logic          Overlap = 1'b0;
    logic          Valid = 1'b0;
    logic          w = 1'b0;

    logic          z_a,  z_b;
    logic [0:0]    id_a, id_b;
    logic [7:0]    hits_a;
    logic [1:0]    hits_b;
    logic [1:0]    st_a, st_b;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    pattern_detector #(.LEN(LEN), .NPAT(NPAT), .CW(8)) dut (
        .Clock(Clock), .Reset(Reset), .Load(Load), .PatIn(PatIn),
        .Overlap(Overlap), .Valid(Valid), .w(w),
        .z(z_a), .MatchId(id_a), .Hits(hits_a), .CurState(st_a)
    );

    pattern_detector #(.LEN(LEN), .NPAT(NPAT), .CW(2)) dut_small (
        .Clock(Clock), .Reset(Reset), .Load(Load), .PatIn(PatIn),
        .Overlap(Overlap), .Valid(Valid), .w(w),
        .z(z_b), .MatchId(id_b), .Hits(hits_b), .CurState(st_b)
    );

    // ---------------- reference model ----------------
    int m_pats [NPAT];
    int m_bits [$];     // most recent consumed bits, oldest first
    int m_avail;        // bits usable toward the next match
    int m_state;        // 0 fill, 1 search, 2 match
    int m_id;
    int m_hits8;
    int m_hits2;

    function automatic int sat_add(input int v, input int maxv);
        return (v < maxv) ? v + 1 : maxv;
    endfunction

    task automatic model_edge(input logic rst, input logic ld, input logic vld,
                              input logic bit_w, input logic ov,
                              input logic [PW-1:0] pat);
        int win;
        int found;
        if (rst) begin
            foreach (m_pats[i]) m_pats[i] = 0;
            m_bits.delete();
            m_avail = 0; m_state = 0; m_id = 0; m_hits8 = 0; m_hits2 = 0;
        end else if (ld) begin
            for (int i = 0; i < NPAT; i++) m_pats[i] = int'(pat[i*LEN +: LEN]);
            m_bits.delete();
            m_avail = 0; m_hits8 = 0; m_hits2 = 0; m_state = 0;
        end else if (vld) begin
            m_bits.push_back(int'(bit_w));
            if (m_bits.size() > LEN) void'(m_bits.pop_front());
            m_avail = (m_avail < LEN) ? m_avail + 1 : LEN;
            win = 0;
            foreach (m_bits[k]) win = (win << 1) | m_bits[k];
            found = -1;
            if (m_avail == LEN) begin
                for (int i = NPAT - 1; i >= 0; i--)
                    if (m_pats[i] == win) found = i;
            end
            if (found >= 0) begin
                m_state = 2; m_id = found;
                m_hits8 = sat_add(m_hits8, 255);
                m_hits2 = sat_add(m_hits2, 3);
                if (!ov) m_avail = 0;
            end else begin
                m_state = (m_avail < LEN) ? 0 : 1;
            end
        end else if (m_state == 2) begin
            m_state = ov ? 1 : 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step(input logic rst, input logic ld, input logic vld,
                        input logic bit_w, input logic ov, input logic [PW-1:0] pat);
        Reset = rst; Load = ld; Valid = vld; w = bit_w; Overlap = ov; PatIn = pat;
        model_edge(rst, ld, vld, bit_w, ov, pat);
        @(posedge Clock);
        #1;
        $display("t=%0t rst=%0b ld=%0b v=%0b w=%0b ov=%0b | z=%0b id=%0d hits=%0d/%0d st=%0d",
                 $time, rst, ld, vld, bit_w, ov, z_a, id_a, hits_a, hits_b, st_a);
        check("z",        int'(z_a),    (m_state == 2) ? 1 : 0);
        check("state",    int'(st_a),   m_state);
        check("matchid",  int'(id_a),   m_id);
        check("hits",     int'(hits_a), m_hits8);
        check("hits_cw2", int'(hits_b), m_hits2);
        check("z_cw2",    int'(z_b),    (m_state == 2) ? 1 : 0);
        check("st_cw2",   int'(st_b),   m_state);
        check("id_cw2",   int'(id_b),   m_id);
    endtask

    task automatic bit_in(input logic b, input logic ov);
        step(1'b0, 1'b0, 1'b1, b, ov, PatIn);
    endtask

    task automatic idle(input logic ov);
        step(1'b0, 1'b0, 1'b0, 1'b0, ov, PatIn);
    endtask

    task automatic load(input logic [PW-1:0] pat);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pat);
    endtask

    localparam logic [PW-1:0] PAT_DEF = {4'b1101, 4'b1111};
    localparam logic [PW-1:0] PAT_DUP = {4'b1010, 4'b1010};

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("reset_state", int'(st_a), 0);
        check("reset_hits",  int'(hits_a), 0);

        // Overlapping: five 1s -> matches after bits 4 and 5
        load(PAT_DEF);
        for (int i = 0; i < 5; i++) bit_in(1'b1, 1'b1);
        check("ovl_hits", int'(hits_a), 2);
        check("ovl_z",    int'(z_a), 1);
        idle(1'b1);
        check("ovl_exit", int'(st_a), 1);

        // Non-overlapping: eight 1s -> matches after bits 4 and 8 only
        load(PAT_DEF);
        for (int i = 0; i < 8; i++) bit_in(1'b1, 1'b0);
        check("novl_hits", int'(hits_a), 2);
        idle(1'b0);
        check("novl_exit", int'(st_a), 0);

        // 1,1,0,1 separated by idle cycles -> pattern 1
        load(PAT_DEF);
        bit_in(1'b1, 1'b1); idle(1'b1);
        bit_in(1'b1, 1'b1); idle(1'b1);
        bit_in(1'b0, 1'b1); idle(1'b1);
        bit_in(1'b1, 1'b1);
        check("gap_id", int'(id_a), 1);
        idle(1'b1);
        check("gap_z_low", int'(z_a), 0);

        // Duplicate patterns -> lowest index wins
        load(PAT_DUP);
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
        check("dup_id", int'(id_a), 0);
        check("dup_z",  int'(z_a), 1);

        // CW=2 saturation: seven 1s in overlap mode
        load(PAT_DEF);
        for (int i = 0; i < 7; i++) bit_in(1'b1, 1'b1);
        check("sat_cw2", int'(hits_b), 3);
        check("sat_cw8", int'(hits_a), 4);

        // Reset mid-pattern discards progress (patterns also cleared)
        load(PAT_DEF);
        bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, PAT_DEF);
        bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
        check("rst_mid_hits", int'(hits_a), 0);

        // Load coincident with Valid drops the bit: three more 1s must not match
        load(PAT_DEF);
        bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, PAT_DEF);
        bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
        check("ld_valid_nomatch", int'(z_a), 0);
        bit_in(1'b1, 1'b1);
        check("ld_valid_match", int'(z_a), 1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [PW-1:0] p;
            r = int'($urandom_range(0, 99));
            p = PW'($urandom);
            if (r < 1)
                step(1'b1, 1'b0, 1'(($urandom & 1)), 1'(($urandom & 1)), 1'(($urandom & 1)), p);
            else if (r < 4)
                step(1'b0, 1'b1, 1'(($urandom & 1)), 1'(($urandom & 1)), 1'(($urandom & 1)), p);
            else
                step(1'b0, 1'b0, 1'($urandom_range(0, 9) < 7), 1'(($urandom & 1)),
                     1'(($urandom & 1)), p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 The block SHALL have parameter LEN, default 4, meaning pattern length in bits (legal 2..16).
REQ-002 The block SHALL have parameter NPAT, default 2, meaning number of programmable patterns (legal 1..4).
REQ-003 The block SHALL have parameter CW, default 8, meaning match-counter width.
REQ-004 The block SHALL have port Clock  in  1  clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Reset  in  1  reset Reset, synchronous, active-high; clock Clock.
REQ-006 The block SHALL have port Load  in  1  strobe that captures PatIn into the pattern registers.
REQ-007 The block SHALL have port PatIn  in  NPAT*LEN  pattern i at bits [i*LEN +: LEN]; MSB is the first-received bit.
REQ-008 The block SHALL have port Overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 The block SHALL have port Valid  in  1  qualifies w; the bit is consumed only when Valid=1.
REQ-010 The block SHALL have port w  in  1  serial input bit.
REQ-011 The block SHALL have port z  out  1  Moore match pulse.
REQ-012 The block SHALL have port MatchId  out  max(1,$clog2(NPAT))  index of the last matched pattern.
REQ-013 The block SHALL have port Hits  out  CW  saturating match count.
REQ-014 The block SHALL have port CurState  out  2  encoded FSM state.

Function
REQ-015 The FSM SHALL have states FILL=2'd0 (fewer than LEN valid history bits), SEARCH=2'd1, MATCH=2'd2; 2'd3 SHALL be unreachable and recover to FILL.
REQ-016 On Valid=1 and Load=0, history SHALL shift: H <= {H[LEN-2:0], w}; fill count SHALL increment, saturating at LEN.
REQ-017 A match SHALL occur when Valid=1, the post-shift fill count equals LEN, and the post-shift history equals some P[i].
REQ-018 On multiple simultaneous pattern hits, the lowest index SHALL win.
REQ-019 On a match: next state MATCH, MatchId <= winning index, Hits <= Hits+1, saturating at 2^CW-1.
REQ-020 Without a match, next state SHALL be FILL if post-shift fill count < LEN, else SEARCH; this applies also when exiting MATCH.
REQ-021 z SHALL equal (CurState==MATCH): a one-cycle pulse, high in the cycle after the edge that consumed the completing bit (latency 1).
REQ-022 Back-to-back matches SHALL hold MATCH, with z high on consecutive cycles.
REQ-023 With Overlap=1 the history SHALL be kept after a match; with Overlap=0 the fill count SHALL clear to 0 on a match, so that no bit is reused.
REQ-024 Cycles with Valid=0 SHALL leave history, fill count, Hits and MatchId unchanged; MATCH SHALL exit to SEARCH (Overlap=1) or FILL (Overlap=0).
REQ-025 Load=1 SHALL capture PatIn, clear history, fill count and Hits, and force FILL; Load SHALL have priority over Valid, and the coincident w SHALL be discarded.
REQ-026 Overlap SHALL be sampled per cycle; a change SHALL take effect on the next match.

Reset
REQ-027 While Reset=1 at an edge: state FILL, H=0, fill count 0, z=0, MatchId=0, Hits=0, all pattern registers 0, CurState=2'd0.
REQ-028 Reset SHALL have priority over Load and Valid; a partial match in progress SHALL be discarded.

Structure
REQ-029 The state enum and its encodings SHALL live in pattern_detector_pkg.
REQ-030 The saturating counter SHALL be a sub-module sat_counter (parameter CW; inputs inc, clr).
REQ-031 All registers SHALL be in a single clocked process; next-state and match logic SHALL be combinational.

Verification (LEN=4, NPAT=2, P0=4'b1111, P1=4'b1101 unless noted)
REQ-032 Overlap=1, w=1,1,1,1,1 with Valid=1 -> z pulses after bits 4 and 5, MatchId=0, Hits=2.
REQ-033 Overlap=0, eight consecutive 1s -> z only after bits 4 and 8, Hits=2, CurState FILL after each match.
REQ-034 w=1,1,0,1 with Valid=0 gaps between bits -> single z after bit 4, MatchId=1, z=0 during gaps.
REQ-035 P0=P1=4'b1010, stream 1,0,1,0 -> z=1 with MatchId=0.
REQ-036 CW=2, Overlap=1, seven 1s -> Hits reads 1,2,3,3; no wrap.
REQ-037 Reset during the third 1 of 1111, then 1,1,1 -> no z, Hits=0; Load coincident with Valid -> bit discarded, fill count 0.
